rand_seq_checker: RTL and testbench

- Receive-side companion to the 16-bit LFSR random generator: consumes the 4-bit rand_num stream, self-synchronises to the generator state and then checks every subsequent nibble.
- Polynomial is fixed: feedback = s[15]^s[14]^s[12]^s[3]. The generator shifts left one bit per enable, inserts feedback at s[0], and outputs s[3:0].
- Sits beside the random-control datapath as a built-in self-check and debug monitor. Provides lock status, a per-error pulse and a saturating error count.

---
 rtl/rand_seq_checker_if.sv | 22 ++
 rtl/rand_seq_checker.sv | 115 +++++++++++
 tb/tb_rand_seq_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rand_seq_checker_if.sv
// Handshake and status bundle between the LFSR stream source and rand_seq_checker.
// The master drives the nibble stream and counter clear. The slave returns lock and error status.
interface rand_seq_checker_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic [3:0]           in_num;
    logic                 clr_cnt;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_num, clr_cnt,
        input  locked, err_pulse, err_count
    );

    modport slave (
        input  in_valid, in_num, clr_cnt,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/rand_seq_checker.sv
// Self-synchronising checker for the 16-bit LFSR nibble stream (fb = s15^s14^s12^s3).
// It rebuilds the generator state from overlapping nibbles, then flywheels and flags mispredictions.
module rand_seq_checker #(
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic              clk,
    input  logic              res,
    rand_seq_checker_if.slave bus
);
    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state, w_state;
    logic [15:0]          r_sh, w_sh;
    logic [4:0]           r_fill, w_fill;
    logic [3:0]           r_consec, w_consec;
    logic                 r_locked;
    logic                 r_err_pulse, w_err;
    logic [ERR_CNT_W-1:0] r_err_count, w_err_count;

    logic                 w_fb;
    logic [3:0]           w_expected;
    logic [15:0]          w_sh_pass;
    logic [4:0]           w_fill_inc;
    logic [3:0]           w_consec_inc;

    assign w_fb         = r_sh[15] ^ r_sh[14] ^ r_sh[12] ^ r_sh[3];
    assign w_expected   = {r_sh[2:0], w_fb};
    assign w_sh_pass    = {r_sh[14:0], bus.in_num[0]};
    assign w_fill_inc   = r_fill + 5'd1;
    assign w_consec_inc = r_consec + 4'd1;

    always_comb begin
        w_state  = r_state;
        w_sh     = r_sh;
        w_fill   = r_fill;
        w_consec = r_consec;
        w_err    = 1'b0;
        if (bus.in_valid) begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (r_fill == 5'd0) begin
                        w_sh[3:0] = bus.in_num;
                        w_fill    = 5'd4;
                    end else if (bus.in_num[3:1] == r_sh[2:0]) begin
                        w_sh   = w_sh_pass;
                        w_fill = w_fill_inc;
                        // A full all-zero register means a stuck generator, so fill restarts instead of locking.
                        if (w_fill_inc == 5'd16) begin
                            if (w_sh_pass != 16'h0000) begin
                                w_state  = ST_LOCKED;
                                w_consec = '0;
                            end else begin
                                w_fill = '0;
                            end
                        end
                    end else begin
                        w_sh[3:0] = bus.in_num;
                        w_fill    = 5'd4;
                    end
                end
                ST_LOCKED: begin
                    w_sh = {r_sh[14:0], w_fb};
                    if (bus.in_num != w_expected) begin
                        w_err    = 1'b1;
                        w_consec = w_consec_inc;
                        if (w_consec_inc == 4'(LOSS_THRESH)) begin
                            w_state = ST_SEARCH;
                            w_fill  = '0;
                        end
                    end else begin
                        w_consec = '0;
                    end
                end
                default: w_state = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        w_err_count = r_err_count;
        if (bus.clr_cnt) begin
            w_err_count = w_err ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_err && (r_err_count != '1)) begin
            w_err_count = r_err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state     <= ST_SEARCH;
            r_sh        <= '0;
            r_fill      <= '0;
            r_consec    <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state;
            r_sh        <= w_sh;
            r_fill      <= w_fill;
            r_consec    <= w_consec;
            r_locked    <= (w_state == ST_LOCKED);
            r_err_pulse <= w_err;
            r_err_count <= w_err_count;
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_rand_seq_checker.sv
// Scoreboard bench for rand_seq_checker: the driver queues the expected registered outputs for each cycle.
// The monitor pops the queue and compares one entry just after every rising edge.
module tb_rand_seq_checker;
    localparam int W = 4;

    typedef struct packed {
        logic         l;
        logic         p;
        logic [W-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic [15:0] g;
    int   ec;

    rand_seq_checker_if #(.ERR_CNT_W(W)) bus ();

    rand_seq_checker #(.LOSS_THRESH(4), .ERR_CNT_W(W)) u_dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gnext(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] num, input logic clr,
                         input logic el, input logic ep, input int c);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_num   = num;
        bus.clr_cnt  = clr;
        e.l = el;
        e.p = ep;
        e.c = W'(c);
        q.push_back(e);
    endtask

    // Correct generator nibble, then advance the generator.
    task automatic good(input logic el, input logic clr);
        drive(1'b1, g[3:0], clr, el, 1'b0, ec);
        g = gnext(g);
    endtask

    // Corrupted nibble; the generator still advances so the flywheel stays aligned.
    task automatic bad(input logic el, input logic clr);
        drive(1'b1, g[3:0] ^ 4'h1, clr, el, 1'b1, ec);
        g = gnext(g);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr_cnt  = 1'b0;
        #2 res = 1'b0;
        #1;
        chk({tag, "_locked"}, 16'(bus.locked), 16'd0);
        chk({tag, "_pulse"},  16'(bus.err_pulse), 16'd0);
        chk({tag, "_count"},  16'(bus.err_count), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        res = 1'b1;
        ec  = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",    16'(bus.locked),    16'(e.l));
                chk("err_pulse", 16'(bus.err_pulse), 16'(e.p));
                chk("err_count", 16'(bus.err_count), 16'(e.c));
            end
        end
    end

    initial begin : stimulus
        int ne;
        bus.in_valid = 1'b0;
        bus.in_num   = 4'h0;
        bus.clr_cnt  = 1'b0;
        ec = 0;
        do_reset("reset");

        // Lock on the generator seeded 0x0403 (stream 0x3, 0x6, 0xC, ...).
        g = 16'h0403;
        for (int i = 1; i <= 13; i++) good(i == 13, 1'b0);

        // Tracking with idle gaps.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0)
                drive(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0, ec);
            good(1'b1, 1'b0);
        end

        // Single error; the following nibbles must still match.
        ec = 1;
        bad(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) good(1'b1, 1'b0);

        // Four consecutive errors lose lock, then 13 good nibbles relock.
        for (int i = 1; i <= 4; i++) begin
            ec++;
            bad(i < 4, 1'b0);
        end
        for (int i = 1; i <= 13; i++) good(i == 13, 1'b0);

        // clr_cnt alone, then together with a mismatch.
        ec = 0;
        good(1'b1, 1'b1);
        ec = 1;
        bad(1'b1, 1'b1);
        good(1'b1, 1'b0);

        // Saturation at 0xF with errors interleaved so lock is kept.
        for (int i = 1; i <= 16; i++) begin
            ne = ec + 1;
            ec = (ne > 15) ? 15 : ne;
            bad(1'b1, 1'b0);
            good(1'b1, 1'b0);
        end

        // Asynchronous reset while locked.
        do_reset("async_reset");

        // Overlap failure on 0x5 restarts the fill; 12 further samples are needed.
        drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 0);
        g = gnext(16'h0005);
        for (int i = 1; i <= 12; i++) good(i == 12, 1'b0);

        // Stuck all-zero stream never locks.
        do_reset("stuck_reset");
        for (int i = 0; i < 20; i++) drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
